// File: rtl/im_loader.sv
// Instruction-memory loader: streams words into consecutive addresses from 0,
// then drains the CPU pipeline before releasing cpu_hold.
`timescale 1ns/1ps
module im_loader #(
   parameter int NMEM      = 20,
   parameter int AW        = 5,
   parameter int DRAIN_CYC = 5
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [AW:0]   len,
   input  logic          s_valid,
   input  logic [31:0]   s_data,
   output logic          s_ready,
   output logic          im_we,
   output logic [AW-1:0] im_waddr,
   output logic [31:0]   im_wdata,
   output logic          cpu_hold,
   output logic          busy,
   output logic          done,
   output logic          err,
   output logic [31:0]   checksum
);
   localparam int DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

   typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

   state_t        state, state_d;
   logic [AW:0]   len_q, cnt;
   logic [DW-1:0] dcnt;
   logic          loaded;
   logic          beat, last_beat, len_ok;

   assign len_ok    = (len != '0) && (len <= (AW+1)'(NMEM));
   assign beat      = s_valid && s_ready;
   assign last_beat = beat && (cnt == len_q - 1'b1);

   assign s_ready  = (state == LOAD);
   assign busy     = (state == LOAD) || (state == DRAIN);
   assign done     = (state == DONE);
   assign cpu_hold = !loaded || busy;

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_d;
   end

   always_comb begin
      state_d = state;
      case (state)
         IDLE:    if (start && len_ok) state_d = LOAD;
         LOAD:    if (last_beat)       state_d = DRAIN;
         DRAIN:   if (dcnt == '0)      state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Write port is registered: a beat accepted at edge N is written at edge N+1.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         im_we    <= 1'b0;
         im_waddr <= '0;
         im_wdata <= '0;
         checksum <= '0;
         err      <= 1'b0;
         loaded   <= 1'b0;
         len_q    <= '0;
         cnt      <= '0;
         dcnt     <= '0;
      end else begin
         im_we <= beat;
         if (beat) begin
            im_waddr <= cnt[AW-1:0];
            im_wdata <= s_data;
            checksum <= checksum + s_data;
            cnt      <= cnt + 1'b1;
         end
         case (state)
            IDLE: if (start) begin
               if (len_ok) begin
                  // Memory contents become stale the moment a reload begins.
                  len_q    <= len;
                  cnt      <= '0;
                  checksum <= '0;
                  err      <= 1'b0;
                  loaded   <= 1'b0;
               end else begin
                  err <= 1'b1;
               end
            end
            LOAD:  if (last_beat) dcnt <= DW'(DRAIN_CYC - 1);
            DRAIN: if (dcnt != '0) dcnt <= dcnt - 1'b1;
            DONE:  loaded <= 1'b1;
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_im_loader.sv
// Scoreboarded bench for im_loader: expected writes are queued as beats are
// accepted and checked against the memory write port as they appear.
`timescale 1ns/1ps
module tb_im_loader;
   localparam int NMEM = 20, AW = 5, DC = 5;

   logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, s_valid = 1'b0;
   logic [AW:0]   len = '0;
   logic [31:0]   s_data = '0;
   logic          s_ready, im_we, cpu_hold, busy, done, err;
   logic [AW-1:0] im_waddr;
   logic [31:0]   im_wdata, checksum;

   typedef struct {logic [AW-1:0] a; logic [31:0] d; int c;} wr_t;
   wr_t         exp_q[$];
   logic [31:0] words[8];
   int          cyc = 0, last_acc = 0, n_cmp = 0, n_err = 0;

   im_loader #(.NMEM(NMEM), .AW(AW), .DRAIN_CYC(DC)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .len(len), .s_valid(s_valid),
      .s_data(s_data), .s_ready(s_ready), .im_we(im_we), .im_waddr(im_waddr),
      .im_wdata(im_wdata), .cpu_hold(cpu_hold), .busy(busy), .done(done),
      .err(err), .checksum(checksum));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Write-port scoreboard: every im_we must match the oldest queued beat.
   always @(negedge clk) begin
      if (im_we === 1'b1) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_write cyc=%0d addr=%0d data=%h", cyc, im_waddr, im_wdata);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            if (im_waddr !== e.a || im_wdata !== e.d || cyc !== e.c) begin
               n_err++;
               $display("FAIL write got addr=%0d data=%h cyc=%0d expected addr=%0d data=%h cyc=%0d",
                        im_waddr, im_wdata, cyc, e.a, e.d, e.c);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   function automatic logic [31:0] sum_words(input int n);
      logic [31:0] s = '0;
      for (int i = 0; i < n; i++) s += words[i];
      return s;
   endfunction

   task automatic start_load(input int l);
      start = 1'b1; len = (AW+1)'(l);
      tick();
      start = 1'b0;
   endtask

   // vp gives s_valid per cycle (LSB first); beyond 16 cycles valid stays high.
   task automatic stream(input int n, input logic [15:0] vp);
      int acc = 0, k = 0;
      while (acc < n && k < 200) begin
         s_valid = (k < 16) ? vp[k] : 1'b1;
         s_data  = s_valid ? words[acc] : 32'hDEAD_BEEF;
         if (s_valid && s_ready) begin
            exp_q.push_back('{a: AW'(acc), d: words[acc], c: cyc + 1});
            last_acc = cyc + 1;
            acc++;
         end
         tick();
         k++;
      end
      s_valid = 1'b0;
      n_cmp++;
      if (acc != n) begin
         n_err++;
         $display("FAIL stream_accept got %0d beats expected %0d", acc, n);
      end
   endtask

   task automatic wait_done(input logic [31:0] exp_sum);
      int i = 0;
      while (done !== 1'b1 && i < 40) begin tick(); i++; end
      n_cmp++;
      if (done !== 1'b1) begin
         n_err++; $display("FAIL done_timeout got no done within 40 cycles");
         return;
      end
      n_cmp++;
      if (cyc !== last_acc + DC) begin
         n_err++; $display("FAIL done_latency got cyc=%0d expected %0d", cyc, last_acc + DC);
      end
      n_cmp++;
      if (checksum !== exp_sum) begin
         n_err++; $display("FAIL checksum got %h expected %h", checksum, exp_sum);
      end
      n_cmp++;
      if ({busy, s_ready, cpu_hold} !== 3'b001) begin
         n_err++; $display("FAIL done_cycle busy/ready/hold got %b expected 001", {busy, s_ready, cpu_hold});
      end
      tick();
      n_cmp++;
      if ({done, cpu_hold, busy} !== 3'b000 || checksum !== exp_sum) begin
         n_err++;
         $display("FAIL after_done done/hold/busy got %b expected 000 checksum=%h", {done, cpu_hold, busy}, checksum);
      end
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++; $display("FAIL pending_writes got %0d outstanding expected 0", exp_q.size());
      end
   endtask

   task automatic check_reset_vals(input string tag);
      n_cmp++;
      if ({s_ready, im_we, busy, done, err, cpu_hold} !== 6'b000001 ||
          im_waddr !== '0 || im_wdata !== '0 || checksum !== '0) begin
         n_err++;
         $display("FAIL %s got rdy/we/busy/done/err/hold=%b addr=%0d data=%h sum=%h expected 000001 0 0 0",
                  tag, {s_ready, im_we, busy, done, err, cpu_hold}, im_waddr, im_wdata, checksum);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) tick();
      check_reset_vals("reset_state");
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_len_err();
      int bad[2] = '{0, NMEM + 1};
      foreach (bad[i]) begin
         start_load(bad[i]);
         n_cmp++;
         if ({err, busy, s_ready, cpu_hold} !== 4'b1001) begin
            n_err++;
            $display("FAIL len_err len=%0d err/busy/ready/hold got %b expected 1001", bad[i], {err, busy, s_ready, cpu_hold});
         end
         tick();
      end
      words[0] = 32'h1234_5678;
      start_load(1);
      n_cmp++;
      if ({err, busy} !== 2'b01) begin
         n_err++; $display("FAIL err_clear err/busy got %b expected 01", {err, busy});
      end
      stream(1, 16'hFFFF);
      wait_done(sum_words(1));
   endtask

   task automatic test_basic();
      words[0] = 32'h2001_0005; words[1] = 32'h2002_0007; words[2] = 32'h0022_1820;
      start_load(3);
      stream(3, 16'hFFFF);
      n_cmp++;
      if ({s_ready, busy} !== 2'b01) begin
         n_err++; $display("FAIL drain_entry ready/busy got %b expected 01", {s_ready, busy});
      end
      wait_done(sum_words(3));
   endtask

   task automatic test_toggle();
      start_load(3);
      stream(3, 16'b10_1001);
      wait_done(sum_words(3));
   endtask

   task automatic test_reset_mid();
      words[0] = 32'h0000_0011; words[1] = 32'h0000_0022;
      words[2] = 32'h0000_0033; words[3] = 32'h0000_0044;
      start_load(4);
      stream(2, 16'hFFFF);
      rst_n = 1'b0;
      tick();
      check_reset_vals("reset_mid_load");
      rst_n = 1'b1;
      repeat (3) tick();
      n_cmp++;
      if ({cpu_hold, busy} !== 2'b10 || exp_q.size() != 0) begin
         n_err++;
         $display("FAIL post_reset hold/busy got %b pending=%0d expected 10 pending=0", {cpu_hold, busy}, exp_q.size());
      end
      start_load(4);
      stream(4, 16'b1111_0110_1101);
      wait_done(sum_words(4));
   endtask

   task automatic test_wrap();
      words[0] = 32'hFFFF_FFFF; words[1] = 32'h0000_0002;
      start_load(2);
      stream(2, 16'hFFFF);
      wait_done(32'h0000_0001);
   endtask

   task automatic test_back_to_back();
      n_cmp++;
      if (cpu_hold !== 1'b0) begin
         n_err++; $display("FAIL reload_pre hold got %b expected 0", cpu_hold);
      end
      words[0] = 32'h0800_0000;
      start_load(1);
      n_cmp++;
      if ({cpu_hold, busy} !== 2'b11) begin
         n_err++; $display("FAIL reload_hold hold/busy got %b expected 11", {cpu_hold, busy});
      end
      tick();
      start_load(3);
      n_cmp++;
      if ({busy, s_ready, err} !== 3'b110) begin
         n_err++; $display("FAIL start_in_load busy/ready/err got %b expected 110", {busy, s_ready, err});
      end
      stream(1, 16'hFFFF);
      wait_done(32'h0800_0000);
   endtask

   initial begin
      test_reset();
      test_len_err();
      test_basic();
      test_toggle();
      test_reset_mid();
      test_wrap();
      test_back_to_back();
      repeat (4) tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500000;
      n_err++;
      $display("FAIL watchdog got timeout expected completion");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
